// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports, the status/response
// signals and the data-memory bus of the arbiter.
//   slave  : arbiter view (requests and mem_rdata in, grants and mem bus out)
//   master : environment view (requesters plus memory)
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          lock1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous data memory between the
// core load/store path (port 0) and a loader/debug master (port 1).
// Every access goes IDLE -> ISSUE (-> RDATA for reads) -> IDLE.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave (requests, grants, read return, memory bus)
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t        state_q, state_d;
  logic          win_q, win_d;      // port that owns the access in flight
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_q, last_d;    // port granted most recently
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic          winner;
  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, busy_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, rdata_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= 1'b1;          // makes port 0 win the first tie
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    winner      = 1'b0;
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    rvalid0_o   = 1'b0;
    rvalid1_o   = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rdata_o     = '0;
    busy_o      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Single requester wins outright; with both pending, a locked
          // port 1 keeps priority until its burst budget runs out, after
          // which plain round robin applies.
          if (bus.req0 ^ bus.req1)
            winner = bus.req1;
          else if (bus.lock1 && (burst_cnt_q < CW'(MAX_BURST)))
            winner = 1'b1;
          else
            winner = ~last_q;

          win_d   = winner;
          we_d    = winner ? bus.we1    : bus.we0;
          addr_d  = winner ? bus.addr1  : bus.addr0;
          wdata_d = winner ? bus.wdata1 : bus.wdata0;
          last_d  = winner;
          if (winner && bus.lock1)
            burst_cnt_d = (burst_cnt_q == CW'(MAX_BURST)) ? burst_cnt_q
                                                         : burst_cnt_q + CW'(1);
          else
            burst_cnt_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        gnt0_o      = ~win_q;
        gnt1_o      = win_q;
        state_d     = we_q ? IDLE : RDATA;
      end
      RDATA: begin
        rvalid0_o = ~win_q;
        rvalid1_o = win_q;
        rdata_o   = bus.mem_rdata;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt0      = gnt0_o;
  assign bus.gnt1      = gnt1_o;
  assign bus.rvalid0   = rvalid0_o;
  assign bus.rvalid1   = rvalid1_o;
  assign bus.rdata     = rdata_o;
  assign bus.busy      = busy_o;
  assign bus.mem_en    = mem_en_o;
  assign bus.mem_we    = mem_we_o;
  assign bus.mem_addr  = mem_addr_o;
  assign bus.mem_wdata = mem_wdata_o;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read memory model, preloaded while reset is held.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'h12345678;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } gexp_t;
  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: compares every grant and every read return against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt0 || bus.gnt1) begin
        if (gq.size() == 0) begin
          chk(1'b0, "unexpected_gnt", {bus.gnt1, bus.gnt0}, 0);
        end else begin
          gexp_t e;
          logic [127:0] a, x;
          e = gq.pop_front();
          a = {bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.mem_addr,
               (bus.mem_we ? bus.mem_wdata : 32'h0)};
          x = {~e.port, e.port, 1'b1, e.we, e.addr, (e.we ? e.data : 32'h0)};
          chk(a == x && !bus.rvalid0 && !bus.rvalid1, "grant", a, x);
        end
      end else if (bus.mem_en) begin
        chk(1'b0, "mem_en_without_gnt", bus.mem_en, 0);
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        if (rq.size() == 0) begin
          chk(1'b0, "unexpected_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
        end else begin
          rexp_t e;
          logic [127:0] a, x;
          e = rq.pop_front();
          a = {bus.rvalid0, bus.rvalid1, bus.rdata};
          x = {~e.port, e.port, e.data};
          chk(a == x && !bus.gnt0 && !bus.gnt1, "rdata", a, x);
        end
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy, bus.mem_en,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk(1'b0, "idle_timeout", 1, 0);
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] data);
    if (port) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data;
    end
  endtask

  // Single-requester access; call on a negedge with the arbiter idle.
  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rexp);
    wait_idle();
    gq.push_back('{port: port, we: we, addr: addr, data: data});
    if (!we) rq.push_back('{port: port, data: rexp});
    drive(port, 1'b1, we, addr, data);
    @(negedge clk);
    chk((port ? bus.gnt1 : bus.gnt0) && bus.busy, "gnt_latency",
        {bus.gnt1, bus.gnt0, bus.busy}, {port, ~port, 1'b1});
    drive(port, 1'b0, we, addr, data);
    if (!we) begin
      @(negedge clk);
      chk((port ? bus.rvalid1 : bus.rvalid0) && bus.busy, "rvalid_latency",
          {bus.rvalid1, bus.rvalid0, bus.busy}, {port, ~port, 1'b1});
    end
    @(negedge clk);
    chk(!bus.busy, "busy_after_access", bus.busy, 0);
  endtask

  // Both ports held requesting until n grants have been seen.
  task automatic held(input int n, input bit burst);
    int g = 0;
    int t = 0;
    while (g < n && t < 60) begin
      @(negedge clk);
      t++;
      if (bus.gnt0 || bus.gnt1) begin
        g++;
        if (burst && g == 4)
          chk(dut.burst_cnt_q == 3'd4, "burst_cnt_full", dut.burst_cnt_q, 4);
        if (burst && g == 5)
          chk(dut.burst_cnt_q == 3'd0, "burst_cnt_clear", dut.burst_cnt_q, 0);
      end
    end
    if (g < n) chk(1'b0, "held_timeout", g, n);
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.lock1 = 1'b0;
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.lock1 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk(all_outs() == 0, "reset_outputs", all_outs(), 0);
    chk(dut.last_q == 1'b1 && dut.burst_cnt_q == 0, "reset_state",
        {dut.last_q, dut.burst_cnt_q}, {1'b1, 3'd0});
    rst = 1'b0;
    @(negedge clk);

    // Single read from port 0
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    // Port 1 write then read back
    access(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D);

    // Round robin with both ports held: 0,1,0,1
    for (int i = 0; i < 2; i++) begin
      gq.push_back('{port: 1'b0, we: 1'b1, addr: 32'h40, data: 32'h11110000});
      gq.push_back('{port: 1'b1, we: 1'b1, addr: 32'h44, data: 32'h22220000});
    end
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h11110000);
    drive(1'b1, 1'b1, 1'b1, 32'h44, 32'h22220000);
    held(4, 1'b0);

    // Burst lock: 1,1,1,1,0,1
    for (int i = 0; i < 4; i++)
      gq.push_back('{port: 1'b1, we: 1'b1, addr: 32'h54, data: 32'hBBBB0000});
    gq.push_back('{port: 1'b0, we: 1'b1, addr: 32'h50, data: 32'hAAAA0000});
    gq.push_back('{port: 1'b1, we: 1'b1, addr: 32'h54, data: 32'hBBBB0000});
    bus.lock1 = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h50, 32'hAAAA0000);
    drive(1'b1, 1'b1, 1'b1, 32'h54, 32'hBBBB0000);
    held(6, 1'b1);

    // Reset during the RDATA cycle of a read: no rvalid may follow
    gq.push_back('{port: 1'b0, we: 1'b0, addr: 32'h30, data: 32'h0});
    drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    chk(bus.gnt0 == 1'b1, "abort_read_gnt", bus.gnt0, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h30, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk(all_outs() == 0, "reset_mid_read_outputs", all_outs(), 0);
    chk(dut.last_q == 1'b1 && dut.burst_cnt_q == 0, "reset_mid_read_state",
        {dut.last_q, dut.burst_cnt_q}, {1'b1, 3'd0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Idle stability
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk(all_outs() == 0, "idle_quiet", all_outs(), 0);
    end

    chk(gq.size() == 0 && rq.size() == 0, "scoreboard_drained",
        {gq.size(), rq.size()}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
